// File: rtl/level_sequencer.sv
// level_sequencer: game-flow controller between the menu/game-logic event
// sources and the VGA drawing blocks. Owns the level_index bus, fades the
// picture between levels with a per-frame brightness ramp, gates gameplay
// through play_enable and strobes load_level when a new map is committed.
//
// Optional feature macro: LEVEL_SEQ_FADE_EN
//   defined   - FADE_OUT/FADE_IN step brightness by FADE_STEP per frame_start
//   undefined - FADE_OUT/FADE_IN last one cycle each, brightness stays 255
//
// Ports:
//   Clk, Reset_n  - clock, asynchronous active-low reset
//   frame_start   - one-cycle pulse per frame
//   select_key    - cycle menu level selection (MENU only)
//   start_key     - start selected level (MENU only, beats select_key)
//   game_won/lost - outcome pulses (PLAY only, lost beats won)
//   level_index   - current level for background/map rendering
//   brightness    - colour scale, 255 = full, 0 = black
//   play_enable   - high only in PLAY
//   load_level    - one-cycle strobe while level_index is committed (LOAD)
//   result_win    - outcome of last game
//   seq_state     - MENU=0 FADE_OUT=1 LOAD=2 FADE_IN=3 PLAY=4 RESULT=5
module level_sequencer #(
    parameter int NUM_LEVELS    = 3,
    parameter int FADE_STEP     = 32,
    parameter int RESULT_FRAMES = 60
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_start,
    input  logic       select_key,
    input  logic       start_key,
    input  logic       game_won,
    input  logic       game_lost,
    output logic [2:0] level_index,
    output logic [7:0] brightness,
    output logic       play_enable,
    output logic       load_level,
    output logic       result_win,
    output logic [2:0] seq_state
);

    localparam int             CW         = $clog2(RESULT_FRAMES + 1);
    localparam logic [CW-1:0]  LAST_FRAME = CW'(RESULT_FRAMES - 1);
    localparam logic [2:0]     LAST_LEVEL = 3'(NUM_LEVELS - 1);

    typedef enum logic [2:0] {
        MENU     = 3'd0,
        FADE_OUT = 3'd1,
        LOAD     = 3'd2,
        FADE_IN  = 3'd3,
        PLAY     = 3'd4,
        RESULT   = 3'd5
    } state_t;

    state_t        state, next_state;
    logic [2:0]    target_level;
    logic          target_play;
    logic [CW-1:0] frame_cnt;
    logic          fade_out_done, fade_in_done;
    logic          play_enable_d, load_level_d;

`ifdef LEVEL_SEQ_FADE_EN
    localparam logic [7:0] STEP = 8'(FADE_STEP);
    logic [8:0] bright_sum;
    logic [7:0] bright_inc, bright_dec;

    // 9-bit sum so the ramp up saturates at 255 instead of wrapping
    assign bright_sum    = {1'b0, brightness} + {1'b0, STEP};
    assign bright_inc    = bright_sum[8] ? 8'hFF : bright_sum[7:0];
    assign bright_dec    = (brightness > STEP) ? (brightness - STEP) : 8'd0;
    assign fade_out_done = frame_start && (bright_dec == 8'd0);
    assign fade_in_done  = frame_start && (bright_inc == 8'hFF);
`else
    assign fade_out_done = 1'b1;
    assign fade_in_done  = 1'b1;
`endif

    assign seq_state = state;

    // state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= MENU;
        else          state <= next_state;
    end

    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            MENU:     if (start_key)     next_state = FADE_OUT;
            FADE_OUT: if (fade_out_done) next_state = LOAD;
            LOAD:                        next_state = FADE_IN;
            FADE_IN:  if (fade_in_done)  next_state = target_play ? PLAY : MENU;
            PLAY:     if (game_lost || game_won) next_state = RESULT;
            RESULT:   if (frame_start && frame_cnt == LAST_FRAME) next_state = FADE_OUT;
            default:                     next_state = MENU;
        endcase
    end

    // output decode; registered below so outputs line up with seq_state
    always_comb begin
        play_enable_d = (next_state == PLAY);
        load_level_d  = (next_state == LOAD);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            level_index  <= 3'd0;
            brightness   <= 8'hFF;
            play_enable  <= 1'b0;
            load_level   <= 1'b0;
            result_win   <= 1'b0;
            target_level <= 3'd0;
            target_play  <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            play_enable <= play_enable_d;
            load_level  <= load_level_d;
            // counter only runs in RESULT, so it is clear on every entry
            if (state != RESULT) frame_cnt <= '0;

            case (state)
                MENU: begin
                    if (start_key) begin
                        target_level <= level_index;
                        target_play  <= 1'b1;
                    end else if (select_key) begin
                        level_index <= (level_index == LAST_LEVEL) ? 3'd0 : level_index + 3'd1;
                    end
                end
`ifdef LEVEL_SEQ_FADE_EN
                FADE_OUT: if (frame_start) brightness <= bright_dec;
                FADE_IN:  if (frame_start) brightness <= bright_inc;
`endif
                PLAY: begin
                    if (game_lost)     result_win <= 1'b0;
                    else if (game_won) result_win <= 1'b1;
                end
                RESULT: begin
                    if (frame_start) begin
                        frame_cnt <= frame_cnt + CW'(1);
                        if (frame_cnt == LAST_FRAME) begin
                            if (!result_win) begin
                                target_level <= level_index;
                                target_play  <= 1'b0;
                            end else if (level_index == LAST_LEVEL) begin
                                target_level <= 3'd0;
                                target_play  <= 1'b0;
                            end else begin
                                target_level <= level_index + 3'd1;
                                target_play  <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase

            // commit the map on the edge entering LOAD so level_index and
            // load_level are both valid during the LOAD cycle
            if (next_state == LOAD) level_index <= target_level;
        end
    end

endmodule
